// File: rtl/bp_fe_pkg.sv
// Shared FE pc_gen types. The source enum is also decoded by the pc_gen
// tracer, so its encoding must not change.
package bp_fe_pkg;

    typedef enum logic [2:0] {
        e_pc_src_undefined            = 3'd0,
        e_pc_src_redirect             = 3'd1,
        e_pc_src_override_ras         = 3'd2,
        e_pc_src_override_branch      = 3'd3,
        e_pc_src_btb_taken_branch     = 3'd4,
        e_pc_src_last_fetch_plus_four = 3'd5
    } bp_fe_pc_gen_src_e;

    typedef enum logic [1:0] {
        e_run    = 2'd0,
        e_wait   = 2'd1,
        e_resume = 2'd2
    } bp_fe_ctrl_state_e;

endpackage

// File: rtl/bp_fe_pc_gen_src_sel.sv
// Combinational next-PC priority mux: picks the fetch PC, its source code
// and the IF1/IF2 kill signals from the controller state and candidates.
module bp_fe_pc_gen_src_sel
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = 39
) (
    input  bp_fe_ctrl_state_e          state_i,
    input  logic                       redirect_v_i,
    input  logic [vaddr_width_p-1:0]   redirect_pc_i,
    input  logic                       hold_v_i,
    input  logic [vaddr_width_p-1:0]   hold_pc_i,
    input  bp_fe_pc_gen_src_e          hold_src_i,
    input  logic                       ras_v_i,
    input  logic [vaddr_width_p-1:0]   ras_pc_i,
    input  logic                       br_ovr_v_i,
    input  logic [vaddr_width_p-1:0]   br_ovr_pc_i,
    input  logic                       btb_taken_v_i,
    input  logic [vaddr_width_p-1:0]   btb_pc_i,
    input  logic [vaddr_width_p-1:0]   last_pc_i,
    input  logic [vaddr_width_p-1:0]   replay_pc_i,
    input  logic                       if2_event_i,
    output logic [vaddr_width_p-1:0]   next_pc_o,
    output bp_fe_pc_gen_src_e          src_o,
    output logic                       next_pc_v_o,
    output logic                       poison_if1_o,
    output logic                       poison_if2_o
);

    localparam logic [vaddr_width_p-1:0] pc_step_lp = {{(vaddr_width_p-3){1'b0}}, 3'b100};

    // Priority selection; a held (not yet accepted) PC re-issues with its
    // original source and kills, and an IF2 event suppresses any fetch.
    always_comb begin
        next_pc_o    = replay_pc_i;
        src_o        = e_pc_src_undefined;
        next_pc_v_o  = 1'b0;
        poison_if1_o = 1'b0;
        poison_if2_o = 1'b0;
        if (redirect_v_i) begin
            next_pc_o    = redirect_pc_i;
            src_o        = e_pc_src_redirect;
            next_pc_v_o  = 1'b1;
            poison_if1_o = 1'b1;
            poison_if2_o = 1'b1;
        end else begin
            case (state_i)
                e_run: begin
                    if (if2_event_i) begin
                        poison_if1_o = 1'b1;
                        poison_if2_o = 1'b1;
                    end else begin
                        next_pc_v_o = 1'b1;
                        if (hold_v_i) begin
                            next_pc_o    = hold_pc_i;
                            src_o        = hold_src_i;
                            poison_if1_o = (hold_src_i == e_pc_src_redirect)
                                         | (hold_src_i == e_pc_src_override_ras)
                                         | (hold_src_i == e_pc_src_override_branch);
                            poison_if2_o = (hold_src_i == e_pc_src_redirect);
                        end else if (ras_v_i) begin
                            next_pc_o    = ras_pc_i;
                            src_o        = e_pc_src_override_ras;
                            poison_if1_o = 1'b1;
                        end else if (br_ovr_v_i) begin
                            next_pc_o    = br_ovr_pc_i;
                            src_o        = e_pc_src_override_branch;
                            poison_if1_o = 1'b1;
                        end else if (btb_taken_v_i) begin
                            next_pc_o    = btb_pc_i;
                            src_o        = e_pc_src_btb_taken_branch;
                        end else begin
                            next_pc_o    = last_pc_i + pc_step_lp;
                            src_o        = e_pc_src_last_fetch_plus_four;
                        end
                    end
                end
                e_resume: begin
                    src_o       = e_pc_src_redirect;
                    next_pc_v_o = 1'b1;
                end
                e_wait: begin
                    src_o       = e_pc_src_undefined;
                end
                default: begin
                    src_o       = e_pc_src_undefined;
                end
            endcase
        end
    end

endmodule

// File: rtl/bp_fe_pc_gen_ctrl.sv
// FE pc_gen controller: run/wait/resume sequencing around IF2 events,
// replay PC capture, wait-cycle counter and next-PC source selection.
module bp_fe_pc_gen_ctrl
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p     = 39,
    parameter int stall_cnt_width_p = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_li,
    input  logic                          redirect_v_i,
    input  logic [vaddr_width_p-1:0]      redirect_pc_i,
    input  logic                          ras_v_i,
    input  logic [vaddr_width_p-1:0]      ras_pc_i,
    input  logic                          br_ovr_v_i,
    input  logic [vaddr_width_p-1:0]      br_ovr_pc_i,
    input  logic                          btb_taken_v_i,
    input  logic [vaddr_width_p-1:0]      btb_pc_i,
    input  logic                          fetch_ready_i,
    input  logic                          if2_v_i,
    input  logic [vaddr_width_p-1:0]      if2_pc_i,
    input  logic                          icache_miss_i,
    input  logic                          itlb_miss_i,
    input  logic                          fault_i,
    input  logic                          queue_full_i,
    input  logic                          resume_i,
    output logic [vaddr_width_p-1:0]      next_pc_o,
    output logic                          next_pc_v_o,
    output logic [2:0]                    pc_src_o,
    output logic                          poison_if1_o,
    output logic                          poison_if2_o,
    output logic [1:0]                    state_o,
    output logic [stall_cnt_width_p-1:0]  stall_cnt_o
);

    bp_fe_ctrl_state_e               state_q, state_d;
    logic [vaddr_width_p-1:0]        last_pc_q, last_pc_d;
    logic [vaddr_width_p-1:0]        replay_pc_q, replay_pc_d;
    logic [stall_cnt_width_p-1:0]    stall_cnt_q, stall_cnt_d;
    logic                            fault_q, fault_d;
    logic                            hold_v_q, hold_v_d;
    logic [vaddr_width_p-1:0]        hold_pc_q, hold_pc_d;
    bp_fe_pc_gen_src_e               hold_src_q, hold_src_d;

    logic                            if2_event_s;
    logic [vaddr_width_p-1:0]        sel_pc_s;
    bp_fe_pc_gen_src_e               sel_src_s;
    logic                            sel_v_s;
    logic                            sel_p1_s;
    logic                            sel_p2_s;

    assign if2_event_s = if2_v_i & (icache_miss_i | itlb_miss_i | fault_i | queue_full_i);

    bp_fe_pc_gen_src_sel #(
        .vaddr_width_p (vaddr_width_p)
    ) src_sel (
        .state_i       (state_q),
        .redirect_v_i  (redirect_v_i),
        .redirect_pc_i (redirect_pc_i),
        .hold_v_i      (hold_v_q),
        .hold_pc_i     (hold_pc_q),
        .hold_src_i    (hold_src_q),
        .ras_v_i       (ras_v_i),
        .ras_pc_i      (ras_pc_i),
        .br_ovr_v_i    (br_ovr_v_i),
        .br_ovr_pc_i   (br_ovr_pc_i),
        .btb_taken_v_i (btb_taken_v_i),
        .btb_pc_i      (btb_pc_i),
        .last_pc_i     (last_pc_q),
        .replay_pc_i   (replay_pc_q),
        .if2_event_i   (if2_event_s),
        .next_pc_o     (sel_pc_s),
        .src_o         (sel_src_s),
        .next_pc_v_o   (sel_v_s),
        .poison_if1_o  (sel_p1_s),
        .poison_if2_o  (sel_p2_s)
    );

    // Output drive; forced to idle values while reset is asserted.
    always_comb begin
        if (!reset_li) begin
            next_pc_o    = {vaddr_width_p{1'b0}};
            next_pc_v_o  = 1'b0;
            pc_src_o     = e_pc_src_undefined;
            poison_if1_o = 1'b0;
            poison_if2_o = 1'b0;
        end else begin
            next_pc_o    = sel_pc_s;
            next_pc_v_o  = sel_v_s;
            pc_src_o     = sel_src_s;
            poison_if1_o = sel_p1_s;
            poison_if2_o = sel_p2_s;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

    // Next-state, replay capture, wait counter and held-PC tracking.
    always_comb begin
        state_d     = state_q;
        replay_pc_d = replay_pc_q;
        fault_d     = fault_q;
        stall_cnt_d = stall_cnt_q;
        if (sel_v_s & fetch_ready_i) begin
            last_pc_d = sel_pc_s;
        end else begin
            last_pc_d = last_pc_q;
        end
        case (state_q)
            e_run: begin
                if (redirect_v_i) begin
                    state_d = e_run;
                end else if (if2_event_s) begin
                    state_d     = e_wait;
                    replay_pc_d = if2_pc_i;
                    fault_d     = fault_i;
                    stall_cnt_d = {stall_cnt_width_p{1'b0}};
                end else begin
                    state_d = e_run;
                end
            end
            e_wait: begin
                if (&stall_cnt_q) begin
                    stall_cnt_d = stall_cnt_q;
                end else begin
                    stall_cnt_d = stall_cnt_q + {{(stall_cnt_width_p-1){1'b0}}, 1'b1};
                end
                if (redirect_v_i) begin
                    state_d = e_run;
                end else if (resume_i & ~fault_q) begin
                    state_d = e_resume;
                end else begin
                    state_d = e_wait;
                end
            end
            e_resume: begin
                if (redirect_v_i | fetch_ready_i) begin
                    state_d = e_run;
                end else begin
                    state_d = e_resume;
                end
            end
            default: begin
                state_d = e_wait;
            end
        endcase
        // A valid PC that IF0 did not take is re-presented next cycle in run.
        hold_v_d   = sel_v_s & ~fetch_ready_i & (state_d == e_run);
        hold_pc_d  = sel_pc_s;
        hold_src_d = sel_src_s;
    end

    // Controller state registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            state_q     <= e_wait;
            last_pc_q   <= {vaddr_width_p{1'b0}};
            replay_pc_q <= {vaddr_width_p{1'b0}};
            stall_cnt_q <= {stall_cnt_width_p{1'b0}};
            fault_q     <= 1'b0;
            hold_v_q    <= 1'b0;
            hold_pc_q   <= {vaddr_width_p{1'b0}};
            hold_src_q  <= e_pc_src_undefined;
        end else begin
            state_q     <= state_d;
            last_pc_q   <= last_pc_d;
            replay_pc_q <= replay_pc_d;
            stall_cnt_q <= stall_cnt_d;
            fault_q     <= fault_d;
            hold_v_q    <= hold_v_d;
            hold_pc_q   <= hold_pc_d;
            hold_src_q  <= hold_src_d;
        end
    end

endmodule
